// File: rtl/display_status_stage.sv
// rtl/display_status_stage.sv - registered VGA colour/sync output with lives, invincibility and game-over state.
// Optional HURT_FLASH_EN: alternate BG/HIT background every FLASH_PERIOD frames while invincible.
module display_status_stage #(
  parameter int COLOUR_BITS  = 2,
  parameter int MAX_LIVES    = 3,
  parameter int IFRAMES      = 60,
  parameter int FLASH_PERIOD = 8,
  parameter logic [3*COLOUR_BITS-1:0] FG_RGB  = {(3*COLOUR_BITS){1'b1}},
  parameter logic [3*COLOUR_BITS-1:0] BG_RGB  = {{COLOUR_BITS{1'b0}}, {COLOUR_BITS{1'b1}}, {COLOUR_BITS{1'b0}}},
  parameter logic [3*COLOUR_BITS-1:0] HIT_RGB = {{COLOUR_BITS{1'b1}}, {(2*COLOUR_BITS){1'b0}}}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pixel_value,
  input  logic                   video_active,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   frame_end,
  input  logic                   hit,
  input  logic                   restart,
  output logic [COLOUR_BITS-1:0] R,
  output logic [COLOUR_BITS-1:0] G,
  output logic [COLOUR_BITS-1:0] B,
  output logic [7:0]             uo_pins,
  output logic [3:0]             lives,
  output logic                   game_over,
  output logic                   invincible
);

  typedef enum logic [1:0] {PLAY, HURT, GAME_OVER} state_t;

  state_t                   state, state_n;
  logic [3:0]               lives_r, lives_n;
  logic [7:0]               iframe_cnt, iframe_n;
  logic                     hit_seen;
  logic                     effective_hit;
  logic                     hsync_d, vsync_d;
  logic [3*COLOUR_BITS-1:0] hurt_bg;
  logic [3*COLOUR_BITS-1:0] rgb_n;

  // A hit landing on the frame_end cycle still belongs to the frame that is ending.
  assign effective_hit = hit_seen | hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PLAY;
      lives_r    <= 4'(MAX_LIVES);
      iframe_cnt <= 8'd0;
    end else begin
      state      <= state_n;
      lives_r    <= lives_n;
      iframe_cnt <= iframe_n;
    end
  end

  always_comb begin
    state_n  = state;
    lives_n  = lives_r;
    iframe_n = iframe_cnt;
    case (state)
      PLAY: begin
        if (frame_end && effective_hit) begin
          if (lives_r > 4'd1) begin
            lives_n  = lives_r - 4'd1;
            iframe_n = 8'(IFRAMES);
            state_n  = HURT;
          end else begin
            lives_n = 4'd0;
            state_n = GAME_OVER;
          end
        end
      end
      HURT: begin
        if (frame_end) begin
          if (iframe_cnt == 8'd1) begin
            iframe_n = 8'd0;
            state_n  = PLAY;
          end else begin
            iframe_n = iframe_cnt - 8'd1;
          end
        end
      end
      GAME_OVER: begin
        if (restart) begin
          lives_n = 4'(MAX_LIVES);
          state_n = PLAY;
        end
      end
      default: state_n = PLAY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_seen <= 1'b0;
    end else if ((state == GAME_OVER && restart) || frame_end) begin
      hit_seen <= 1'b0;
    end else if (hit) begin
      hit_seen <= 1'b1;
    end
  end

`ifdef HURT_FLASH_EN
  localparam int FW = $clog2(FLASH_PERIOD) + 1;
  logic [FW-1:0] flash_cnt;

  // Restarting at zero makes every invincibility window open on the normal background.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_cnt <= '0;
    end else if (state != HURT && state_n == HURT) begin
      flash_cnt <= '0;
    end else if (frame_end) begin
      flash_cnt <= flash_cnt + FW'(1);
    end
  end

  assign hurt_bg = flash_cnt[FW-1] ? HIT_RGB : BG_RGB;
`else
  assign hurt_bg = BG_RGB;
`endif

  always_comb begin
    rgb_n = '0;
    if (video_active) begin
      if (pixel_value) begin
        rgb_n = FG_RGB;
      end else begin
        case (state)
          HURT:      rgb_n = hurt_bg;
          GAME_OVER: rgb_n = HIT_RGB;
          default:   rgb_n = BG_RGB;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R       <= '0;
      G       <= '0;
      B       <= '0;
      hsync_d <= 1'b0;
      vsync_d <= 1'b0;
    end else begin
      {R, G, B} <= rgb_n;
      hsync_d   <= hsync_in;
      vsync_d   <= vsync_in;
    end
  end

  assign uo_pins = {hsync_d, B[COLOUR_BITS-2], G[COLOUR_BITS-2], R[COLOUR_BITS-2],
                    vsync_d, B[COLOUR_BITS-1], G[COLOUR_BITS-1], R[COLOUR_BITS-1]};

  assign lives      = lives_r;
  assign game_over  = (state == GAME_OVER);
  assign invincible = (state == HURT);

endmodule

// File: tb/tb_display_status_stage.sv
// tb/tb_display_status_stage.sv - directed self-checking bench for display_status_stage.
module tb_display_status_stage;

  logic       clk = 1'b0;
  logic       rst_n, pixel_value, video_active, hsync_in, vsync_in;
  logic       frame_end, hit, restart;
  logic [1:0] R, G, B;
  logic [7:0] uo_pins;
  logic [3:0] lives;
  logic       game_over, invincible;
  logic [1:0] sr, sg;
  int         checks = 0;
  int         failures = 0;

`ifdef HURT_FLASH_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif

  always #5 clk = ~clk;

  display_status_stage dut (
    .clk(clk), .rst_n(rst_n), .pixel_value(pixel_value), .video_active(video_active),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_end(frame_end), .hit(hit),
    .restart(restart), .R(R), .G(G), .B(B), .uo_pins(uo_pins), .lives(lives),
    .game_over(game_over), .invincible(invincible)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Four-cycle frame; colour is sampled after the first cycle, hit is driven
  // on the first cycle and/or the frame_end cycle.
  task automatic run_frame(input logic h_mid, input logic h_end,
                           output logic [1:0] r, output logic [1:0] g);
    hit = h_mid;
    tick();
    r = R;
    g = G;
    hit = 1'b0;
    tick();
    tick();
    hit = h_end;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    hit = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pixel_value = 1'b1; video_active = 1'b1;
    hsync_in = 1'b0; vsync_in = 1'b0; frame_end = 1'b0; hit = 1'b0; restart = 1'b0;
    #1;
    tick();
    tick();
    check("reset_rgb", {R, G, B}, 6'h00);
    check("reset_lives", lives, 4'd3);
    check("reset_go", game_over, 1'b0);
    check("reset_inv", invincible, 1'b0);
    check("reset_pins", uo_pins, 8'h00);

    rst_n = 1'b1;
    tick();
    check("fg_rgb", {R, G, B}, 6'h3F);
    check("fg_pins", uo_pins, 8'b0111_0111);

    #2 rst_n = 1'b0;
    #1;
    check("async_rgb", {R, G, B}, 6'h00);
    check("async_lives", lives, 4'd3);
    rst_n = 1'b1;
    tick();
    check("post_async_fg", {R, G, B}, 6'h3F);

    pixel_value = 1'b0;
    tick();
    check("bg_rgb", {R, G, B}, 6'b00_11_00);
    check("bg_pins", uo_pins, 8'b0010_0010);
    hsync_in = 1'b1; vsync_in = 1'b1;
    tick();
    check("sync_pins", uo_pins, 8'b1010_1010);
    hsync_in = 1'b0; vsync_in = 1'b0; video_active = 1'b0;
    tick();
    check("blank_rgb", {R, G, B}, 6'h00);
    check("blank_pins", uo_pins, 8'h00);
    video_active = 1'b1;

    run_frame(1'b1, 1'b0, sr, sg);
    check("play_bg_g", sg, 2'd3);
    check("hit1_lives", lives, 4'd2);
    check("hit1_inv", invincible, 1'b1);

    for (int i = 0; i < 60; i++) begin
      run_frame(1'b1, 1'b1, sr, sg);
      check("hurt_bg_r", sr, (FLASH && i[3]) ? 2'd3 : 2'd0);
      check("hurt_bg_g", sg, (FLASH && i[3]) ? 2'd0 : 2'd3);
      check("hurt_lives", lives, 4'd2);
      check("hurt_inv", invincible, (i < 59) ? 1'b1 : 1'b0);
    end

    run_frame(1'b0, 1'b1, sr, sg);
    check("end_hit_bg_g", sg, 2'd3);
    check("end_hit_lives", lives, 4'd1);
    check("end_hit_inv", invincible, 1'b1);
    for (int i = 0; i < 60; i++) begin
      run_frame(1'b0, 1'b0, sr, sg);
      check("hurt2_lives", lives, 4'd1);
    end
    check("hurt2_done", invincible, 1'b0);
    run_frame(1'b0, 1'b0, sr, sg);
    check("quiet_lives", lives, 4'd1);

    run_frame(1'b1, 1'b0, sr, sg);
    check("last_lives", lives, 4'd0);
    check("last_go", game_over, 1'b1);
    check("last_inv", invincible, 1'b0);
    run_frame(1'b1, 1'b1, sr, sg);
    check("go_bg_r", sr, 2'd3);
    check("go_bg_g", sg, 2'd0);
    check("go_lives", lives, 4'd0);
    check("go_held", game_over, 1'b1);

    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_lives", lives, 4'd3);
    check("restart_go", game_over, 1'b0);
    tick();
    check("restart_bg_g", G, 2'd3);
    check("restart_bg_r", R, 2'd0);

    run_frame(1'b1, 1'b0, sr, sg);
    check("rehit_lives", lives, 4'd2);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_in_hurt_lives", lives, 4'd2);
    check("restart_in_hurt_inv", invincible, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
